// File: rtl/mlp_seq_engine.sv
// Three-layer MLP evaluated with a single time-multiplexed signed MAC; weights and biases
// stream sequentially from an external synchronous memory, and the result is a registered argmax.
module mlp_seq_engine #(
    parameter int DW    = 8,
    parameter int N_IN  = 62,
    parameter int N_HID = 10,
    parameter int N_OUT = 10,
    parameter int ACC_W = 21,
    parameter int SHIFT = 7,
    parameter int AW    = $clog2(N_HID*(N_IN+1) + N_HID*(N_HID+1) + N_OUT*(N_HID+1)),
    parameter int CW    = $clog2(N_OUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_IN*DW-1:0]   in_data,
    output logic                 w_rd_en,
    output logic [AW-1:0]        w_addr,
    input  logic signed [DW-1:0] w_data,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        class_out,
    output logic signed [DW-1:0] score_out
);
    localparam int CNT_W = $clog2(N_IN + 3);
    localparam int MAX_N = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int NEU_W = $clog2(MAX_N + 1);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2**(DW-1) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(2**(DW-1)));

    typedef enum logic [2:0] {IDLE, L0, L1, L2, DONE} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt, fan_in, idx;
    logic [NEU_W-1:0]         neu, last_neu;
    logic                     in_layer, wb, last_wb, mac_w, mac_b, better;
    logic                     vld_p1;
    logic [N_IN*DW-1:0]       x_buf;
    logic [N_HID*DW-1:0]      h0_buf, h1_buf;
    logic signed [DW-1:0]     op_sel, res_p2, best_score;
    logic [NEU_W-1:0]         best_idx;
    logic signed [ACC_W-1:0]  acc_p1, op_ext, w_ext;

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s > MAX_V)      return MAX_V[DW-1:0];
        else if (s < MIN_V) return MIN_V[DW-1:0];
        else                return s[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
        return v[DW-1] ? '0 : v;
    endfunction

    // Per neuron: cnt 0..fan_in issue reads, fan_in+1 drains the bias, fan_in+2 writes back.
    assign in_layer = (state == L0) || (state == L1) || (state == L2);
    assign fan_in   = (state == L0) ? CNT_W'(N_IN) : CNT_W'(N_HID);
    assign last_neu = (state == L2) ? NEU_W'(N_OUT - 1) : NEU_W'(N_HID - 1);
    assign wb       = in_layer && (cnt == fan_in + CNT_W'(2));
    assign last_wb  = wb && (neu == last_neu);
    assign idx      = cnt - CNT_W'(1);
    assign mac_w    = vld_p1 && (cnt <= fan_in);
    assign mac_b    = vld_p1 && (cnt == fan_in + CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)   state_nxt = L0;
            L0:      if (last_wb) state_nxt = L1;
            L1:      if (last_wb) state_nxt = L2;
            L2:      if (last_wb) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        w_rd_en = in_layer && (cnt <= fan_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            neu    <= '0;
            w_addr <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= w_rd_en;
            if (!in_layer || wb) cnt <= '0;
            else                 cnt <= cnt + CNT_W'(1);
            if (!in_layer)       neu <= '0;
            else if (wb)         neu <= (neu == last_neu) ? '0 : neu + NEU_W'(1);
            if (state == IDLE)   w_addr <= '0;
            else if (w_rd_en)    w_addr <= w_addr + AW'(1);
        end
    end

    always_comb begin
        op_sel = '0;
        unique case (state)
            L0:      op_sel = x_buf[idx*DW +: DW];
            L1:      op_sel = h0_buf[idx*DW +: DW];
            L2:      op_sel = h1_buf[idx*DW +: DW];
            default: op_sel = '0;
        endcase
    end

    assign op_ext = ACC_W'(op_sel);
    assign w_ext  = ACC_W'(w_data);
    assign res_p2 = sat_dw(acc_p1);
    assign better = (neu == '0) || (res_p2 > best_score);

    // p1: memory word returns one cycle after its read and is folded into the accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p1 <= '0;
            x_buf  <= '0;
        end else begin
            if (state == IDLE && start) x_buf <= in_data;
            if (in_layer && cnt == '0)  acc_p1 <= '0;
            else if (mac_w)             acc_p1 <= acc_p1 + op_ext * w_ext;
            else if (mac_b)             acc_p1 <= acc_p1 + (w_ext <<< SHIFT);
        end
    end

    // p2: writeback of the saturated neuron result; argmax result lands as DONE begins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h0_buf     <= '0;
            h1_buf     <= '0;
            best_score <= '0;
            best_idx   <= '0;
            class_out  <= '0;
            score_out  <= '0;
        end else if (wb) begin
            if (state == L0) h0_buf[neu*DW +: DW] <= relu(res_p2);
            if (state == L1) h1_buf[neu*DW +: DW] <= relu(res_p2);
            if (state == L2) begin
                if (better) begin
                    best_score <= res_p2;
                    best_idx   <= neu;
                end
                if (last_wb) begin
                    class_out <= better ? CW'(neu) : CW'(best_idx);
                    score_out <= better ? res_p2 : best_score;
                end
            end
        end
    end
endmodule

// File: tb/tb_mlp_seq_engine.sv
// Bench for mlp_seq_engine: directed vector table, randomized runs against a plain-arithmetic
// network model, start-while-busy and mid-run reset sequences.
module tb_mlp_seq_engine;
    localparam int DW = 8, N_IN = 62, N_HID = 10, N_OUT = 10, SHIFT = 7, SCALE = 128;
    localparam int TOTAL = N_HID*(N_IN+1) + N_HID*(N_HID+1) + N_OUT*(N_HID+1);
    localparam int AW = $clog2(TOTAL), CW = $clog2(N_OUT);
    localparam int T_LAT = N_HID*(N_IN+3) + N_HID*(N_HID+3) + N_OUT*(N_HID+3) + 1;
    localparam int L1_BASE = N_HID*(N_IN+1);
    localparam int L2_BASE = L1_BASE + N_HID*(N_HID+1);

    logic clk = 1'b0, rst, start;
    logic [N_IN*DW-1:0] in_data;
    logic w_rd_en, busy, done;
    logic [AW-1:0] w_addr;
    logic signed [DW-1:0] w_data, score_out;
    logic [CW-1:0] class_out;

    mlp_seq_engine dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .busy(busy), .done(done), .class_out(class_out), .score_out(score_out)
    );

    always #5 clk = ~clk;

    int mem[2**AW];
    int xv[N_IN];
    int checks = 0, errors = 0;
    int rd_count = 0, addr_err = 0, rd_base = 0, err_base = 0;

    // Synchronous weight memory; also checks that each run reads addresses 0,1,2,... in order.
    always @(posedge clk) begin
        if (w_rd_en) begin
            if (int'(w_addr) != rd_count - rd_base) addr_err <= addr_err + 1;
            rd_count <= rd_count + 1;
            w_data   <= DW'(mem[w_addr]);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int satq(input int a);
        int q;
        q = (a >= 0) ? a / SCALE : -((-a + SCALE - 1) / SCALE);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    // Network evaluated straight from the memory image with ordinary integer arithmetic.
    function automatic void model(output int cls, output int scr);
        int h0[N_HID], h1[N_HID], o[N_OUT];
        int p, a;
        p = 0;
        for (int n = 0; n < N_HID; n++) begin
            a = 0;
            for (int i = 0; i < N_IN; i++) begin a += xv[i] * mem[p]; p++; end
            a += mem[p] * SCALE; p++;
            h0[n] = (satq(a) < 0) ? 0 : satq(a);
        end
        for (int n = 0; n < N_HID; n++) begin
            a = 0;
            for (int i = 0; i < N_HID; i++) begin a += h0[i] * mem[p]; p++; end
            a += mem[p] * SCALE; p++;
            h1[n] = (satq(a) < 0) ? 0 : satq(a);
        end
        for (int n = 0; n < N_OUT; n++) begin
            a = 0;
            for (int i = 0; i < N_HID; i++) begin a += h1[i] * mem[p]; p++; end
            a += mem[p] * SCALE; p++;
            o[n] = satq(a);
        end
        cls = 0;
        for (int n = 1; n < N_OUT; n++) if (o[n] > o[cls]) cls = n;
        scr = o[cls];
    endfunction

    task automatic set_kind(input int k);
        int l2b[N_OUT];
        for (int a = 0; a < 2**AW; a++) mem[a] = 0;
        for (int i = 0; i < N_IN; i++) xv[i] = 0;
        case (k)
            0: for (int j = 0; j < N_OUT; j++) mem[L2_BASE + j*(N_HID+1) + N_HID] = j;
            1, 2: begin
                for (int i = 0; i < N_IN; i++) xv[i] = 127;
                for (int n = 0; n < N_HID; n++)
                    for (int i = 0; i < N_IN; i++) mem[n*(N_IN+1) + i] = 127;
                if (k == 2) begin
                    for (int n = 0; n < N_HID; n++)
                        for (int i = 0; i < N_HID; i++) mem[L1_BASE + n*(N_HID+1) + i] = 127;
                    mem[L2_BASE + 3*(N_HID+1)] = 127;
                end
            end
            3: begin
                xv[0] = 64;
                mem[0] = -64;
                mem[L1_BASE] = -127;
                mem[L2_BASE + 5*(N_HID+1)] = 127;
            end
            4: begin
                l2b = '{5, 9, 9, 3, 0, 0, 0, 0, 0, 0};
                for (int j = 0; j < N_OUT; j++) mem[L2_BASE + j*(N_HID+1) + N_HID] = l2b[j];
            end
            5, 6: for (int j = 0; j < N_OUT; j++)
                mem[L2_BASE + j*(N_HID+1) + N_HID] = (k == 5 && j == 7) ? -1 : -128;
            default: ;
        endcase
    endtask

    task automatic pack_in();
        for (int i = 0; i < N_IN; i++) in_data[i*DW +: DW] = DW'(xv[i]);
    endtask

    task automatic start_run(input string nm);
        rd_base  = rd_count;
        err_base = addr_err;
        pack_in();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < N_IN; i++) in_data[i*DW +: DW] = DW'($urandom);
        chk({nm, "_busy_on"}, int'(busy), 1);
    endtask

    // cyc numbers the clock cycles after the accept edge (cycle 1 follows it directly);
    // done must appear in cycle T_LAT only, with busy high through it.
    task automatic wait_done(input string nm, input int ecls, input int escr, input bit poke);
        int cyc = 1, first = 0, dones = 0, drop = 0, got_c = -1, got_s = -999, busy_at = 0;
        while (cyc < T_LAT + 20) begin
            if (done === 1'b1) begin
                dones++;
                if (first == 0) begin
                    first = cyc; got_c = int'(class_out); got_s = int'(score_out); busy_at = int'(busy);
                end
            end
            if (first == 0 && busy !== 1'b1) drop++;
            start = (poke && (cyc == 10 || cyc == 400 || cyc == T_LAT)) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1 cyc++;
        end
        start = 1'b0;
        chk({nm, "_latency"}, first, T_LAT);
        chk({nm, "_done_count"}, dones, 1);
        chk({nm, "_class"}, got_c, ecls);
        chk({nm, "_score"}, got_s, escr);
        chk({nm, "_busy_at_done"}, busy_at, 1);
        chk({nm, "_busy_drops"}, drop, 0);
        chk({nm, "_busy_after"}, int'(busy), 0);
        chk({nm, "_reads"}, rd_count - rd_base, TOTAL);
        chk({nm, "_addr_order"}, addr_err - err_base, 0);
    endtask

    typedef struct {
        string name;
        int    kind;
        bit    poke;
        int    cls;
        int    scr;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int ec, es;
        tbl[0] = '{"zero_w_bias_j", 0, 1'b0, 9, 9};
        tbl[1] = '{"l0_saturate", 1, 1'b0, 0, 0};
        tbl[2] = '{"sat_probe", 2, 1'b0, 3, 126};
        tbl[3] = '{"relu_neg", 3, 1'b0, 0, 0};
        tbl[4] = '{"tie_low_idx", 4, 1'b1, 1, 9};
        tbl[5] = '{"neg_scores", 5, 1'b0, 7, -1};
        tbl[6] = '{"all_min", 6, 1'b0, 0, -128};

        rst = 1'b1; start = 1'b0; in_data = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(w_rd_en), 0);
        chk("rst_addr", int'(w_addr), 0);
        chk("rst_class", int'(class_out), 0);
        chk("rst_score", int'(score_out), 0);
        @(negedge clk) rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            set_kind(tbl[t].kind);
            start_run(tbl[t].name);
            wait_done(tbl[t].name, tbl[t].cls, tbl[t].scr, tbl[t].poke);
        end

        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < TOTAL; a++)
                mem[a] = (r % 2 == 0) ? int'($urandom_range(0, 255)) - 128
                                      : int'($urandom_range(0, 40)) - 20;
            for (int i = 0; i < N_IN; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
            model(ec, es);
            start_run($sformatf("rand%0d", r));
            wait_done($sformatf("rand%0d", r), ec, es, 1'b0);
        end

        // Abort a run at cycle 300 with reset, then restart on the first edge after release.
        set_kind(5);
        start_run("abort");
        repeat (299) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_rd_en", int'(w_rd_en), 0);
        chk("abort_addr", int'(w_addr), 0);
        chk("abort_class", int'(class_out), 0);
        chk("abort_score", int'(score_out), 0);
        #2 rst = 1'b0;
        rd_base  = rd_count;
        err_base = addr_err;
        pack_in();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("restart_busy_on", int'(busy), 1);
        wait_done("restart", 7, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
